// File: rtl/imem_stream_loader.sv
// Byte-stream program loader: parses a count/data/checksum frame and fills the
// 16-bit instruction memory, releasing the CPU once a frame verifies.
module imem_stream_loader #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_run,
  output logic              load_err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_CNT_HI,
    S_CNT_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [16:0]       DEPTH_L = 17'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_W   = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [15:0]         count_q, count_d;
  logic [7:0]          hi_q, hi_d;
  logic [7:0]          sum_q, sum_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [1:0]          err_code_q, err_code_d;
  logic                accept;
  logic [15:0]         n_new;

  assign in_ready     = (state_q != S_DONE) && (state_q != S_ERR);
  assign accept       = in_valid && in_ready;
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_run      = (state_q == S_DONE);
  assign load_err     = (state_q == S_ERR);
  assign err_code     = err_code_q;
  assign words_loaded = words_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    hi_d       = hi_q;
    sum_d      = sum_q;
    words_d    = words_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    err_code_d = err_code_q;
    n_new      = {count_q[15:8], in_data};

    case (state_q)
      S_CNT_HI: if (accept) begin
        count_d[15:8] = in_data;
        sum_d         = sum_q + in_data;
        state_d       = S_CNT_LO;
      end
      S_CNT_LO: if (accept) begin
        count_d[7:0] = in_data;
        sum_d        = sum_q + in_data;
        if (n_new == 16'd0) begin
          state_d = S_CSUM;
        end else if ({1'b0, n_new} > DEPTH_L) begin
          state_d    = S_ERR;
          err_code_d = 2'b01;
        end else begin
          state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: if (accept) begin
        hi_d    = in_data;
        sum_d   = sum_q + in_data;
        state_d = S_DATA_LO;
      end
      // The strobe, its address and the incremented count all appear together next cycle.
      S_DATA_LO: if (accept) begin
        sum_d   = sum_q + in_data;
        we_d    = 1'b1;
        wdata_d = {hi_q, in_data};
        addr_d  = BASE + words_q[ADDR_W-1:0];
        words_d = words_q + ONE_W;
        if (17'(words_q) + 17'd1 < {1'b0, count_q}) begin
          state_d = S_DATA_HI;
        end else begin
          state_d = S_CSUM;
        end
      end
      S_CSUM: if (accept) begin
        if (in_data == sum_q) begin
          state_d = S_DONE;
        end else begin
          state_d    = S_ERR;
          err_code_d = 2'b10;
        end
      end
      S_DONE, S_ERR: if (restart) begin
        state_d    = S_CNT_HI;
        count_d    = 16'd0;
        sum_d      = 8'd0;
        words_d    = '0;
        addr_d     = BASE;
        err_code_d = 2'b00;
      end
      default: state_d = S_CNT_HI;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_CNT_HI;
      count_q    <= 16'd0;
      hi_q       <= 8'd0;
      sum_q      <= 8'd0;
      words_q    <= '0;
      addr_q     <= BASE;
      wdata_q    <= 16'd0;
      we_q       <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      hi_q       <= hi_d;
      sum_q      <= sum_d;
      words_q    <= words_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      err_code_q <= err_code_d;
    end
  end

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed bench for imem_stream_loader: a frame-level reference model checked
// every cycle, plus literal expectations taken straight from the frame rules.
module tb_imem_stream_loader;

  localparam int ADDR_W    = 8;
  localparam int DEPTH     = 256;
  localparam int BASE_ADDR = 0;

  typedef logic [7:0] frame_t[$];

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              restart;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              cpu_run;
  logic              load_err;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   words_loaded;

  int checks = 0;
  int errors = 0;
  logic [23:0] wlog[$];

  imem_stream_loader #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .restart(restart), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_run(cpu_run),
    .load_err(load_err), .err_code(err_code), .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: tracks the byte position inside the frame and derives
  // everything from the frame layout (2 count bytes, 2N data bytes, csum).
  bit          m_done, m_err, m_we;
  int          m_idx, m_n, m_words;
  logic [7:0]  m_cnt_hi, m_hi, m_sum;
  logic [ADDR_W-1:0] m_addr;
  logic [15:0] m_wdata;
  logic [1:0]  m_code;

  always @(posedge clk or negedge reset) begin
    if (!reset || (restart && (m_done || m_err))) begin
      m_done = 0; m_err = 0; m_we = 0; m_idx = 0; m_n = 0; m_words = 0;
      m_sum = 8'd0; m_code = 2'b00; m_addr = ADDR_W'(BASE_ADDR);
      if (!reset) begin
        m_wdata = 16'd0; m_hi = 8'd0; m_cnt_hi = 8'd0;
      end
    end else begin
      m_we = 0;
      if (in_valid && !m_done && !m_err) begin
        if (m_idx == 0) begin
          m_cnt_hi = in_data;
          m_sum = m_sum + in_data;
        end else if (m_idx == 1) begin
          m_n = int'(m_cnt_hi) * 256 + int'(in_data);
          m_sum = m_sum + in_data;
          if (m_n > DEPTH) begin
            m_err = 1; m_code = 2'b01;
          end
        end else if (m_idx < 2 * m_n + 2) begin
          m_sum = m_sum + in_data;
          if (m_idx % 2 == 0) m_hi = in_data;
          else begin
            m_we = 1;
            m_addr = ADDR_W'((BASE_ADDR + m_words) % (1 << ADDR_W));
            m_wdata = {m_hi, in_data};
            m_words++;
          end
        end else begin
          if (in_data == m_sum) m_done = 1;
          else begin
            m_err = 1; m_code = 2'b10;
          end
        end
        m_idx++;
      end
    end
  end

  task automatic compareCycle();
    logic [6+ADDR_W:0] exp_v, act_v;
    exp_v = {!(m_done || m_err), m_we, m_done, m_err, m_code, (ADDR_W+1)'(m_words)};
    act_v = {in_ready, imem_we, cpu_run, load_err, err_code, words_loaded};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("[TB] FAIL cycle_outputs t=%0t {rdy,we,run,err,code,words} got=%h want=%h",
               $time, act_v, exp_v);
    end
    if (m_we) begin
      checks++;
      if ({imem_addr, imem_wdata} !== {m_addr, m_wdata}) begin
        errors++;
        $display("[TB] FAIL write_beat t=%0t addr/data got=%h/%h want=%h/%h",
                 $time, imem_addr, imem_wdata, m_addr, m_wdata);
      end
    end
    if (imem_we) wlog.push_back({imem_addr, imem_wdata});
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    repeat (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic sendFrame(input frame_t f, input int max_gap);
    foreach (f[i]) applyStimulus(f[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    idle(3);
  endtask

  task automatic pulseRestart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  initial begin
    frame_t f;
    reset = 1'b0; in_valid = 1'b0; in_data = 8'h00; restart = 1'b0;
    fork
      forever begin
        @(negedge clk);
        compareCycle();
      end
    join_none

    repeat (2) @(negedge clk);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_cpu_run", 32'(cpu_run), 32'd0);
    checkOutput("reset_addr", 32'(imem_addr), 32'(BASE_ADDR));
    checkOutput("reset_wdata", 32'(imem_wdata), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Good frame: 00+02+A1+23+B4+56 = 0x1D0, so the csum byte is D0.
    wlog.delete();
    f = '{8'h00, 8'h02, 8'hA1, 8'h23, 8'hB4, 8'h56, 8'hD0};
    sendFrame(f, 0);
    checkOutput("good_nwrites", 32'(wlog.size()), 32'd2);
    checkOutput("good_write0", 32'(wlog[0]), 32'h00A123);
    checkOutput("good_write1", 32'(wlog[1]), 32'h01B456);
    checkOutput("good_words", 32'(words_loaded), 32'd2);
    checkOutput("good_cpu_run", 32'(cpu_run), 32'd1);
    checkOutput("good_load_err", 32'(load_err), 32'd0);

    pulseRestart();
    checkOutput("restart_cpu_run", 32'(cpu_run), 32'd0);
    checkOutput("restart_addr", 32'(imem_addr), 32'(BASE_ADDR));
    checkOutput("restart_words", 32'(words_loaded), 32'd0);

    // Bad checksum: both writes still land, then ERR with code 10.
    wlog.delete();
    f = '{8'h00, 8'h02, 8'hA1, 8'h23, 8'hB4, 8'h56, 8'hD1};
    sendFrame(f, 0);
    checkOutput("badsum_nwrites", 32'(wlog.size()), 32'd2);
    checkOutput("badsum_load_err", 32'(load_err), 32'd1);
    checkOutput("badsum_code", 32'(err_code), 32'd2);
    checkOutput("badsum_cpu_run", 32'(cpu_run), 32'd0);
    checkOutput("badsum_in_ready", 32'(in_ready), 32'd0);

    // Oversize count 0x0101 > 256; trailing bytes must not be consumed.
    pulseRestart();
    wlog.delete();
    f = '{8'h01, 8'h01, 8'h02, 8'h03};
    sendFrame(f, 0);
    checkOutput("oversize_code", 32'(err_code), 32'd1);
    checkOutput("oversize_nwrites", 32'(wlog.size()), 32'd0);
    checkOutput("oversize_in_ready", 32'(in_ready), 32'd0);
    checkOutput("oversize_load_err", 32'(load_err), 32'd1);

    // Empty frame.
    pulseRestart();
    wlog.delete();
    f = '{8'h00, 8'h00, 8'h00};
    sendFrame(f, 0);
    checkOutput("empty_cpu_run", 32'(cpu_run), 32'd1);
    checkOutput("empty_words", 32'(words_loaded), 32'd0);
    checkOutput("empty_nwrites", 32'(wlog.size()), 32'd0);

    // Four words with random gaps: sum = 4 + 0x264 = 0x268 -> csum 68.
    pulseRestart();
    wlog.delete();
    f = '{8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h68};
    sendFrame(f, 3);
    checkOutput("gaps_nwrites", 32'(wlog.size()), 32'd4);
    checkOutput("gaps_write3", 32'(wlog[3]), 32'h037788);
    checkOutput("gaps_words", 32'(words_loaded), 32'd4);
    checkOutput("gaps_cpu_run", 32'(cpu_run), 32'd1);

    pulseRestart();
    checkOutput("restart2_cpu_run", 32'(cpu_run), 32'd0);
    checkOutput("restart2_addr", 32'(imem_addr), 32'(BASE_ADDR));
    // 01 + DE + AD = 0x18C -> csum 8C.
    wlog.delete();
    f = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'h8C};
    sendFrame(f, 2);
    checkOutput("second_write0", 32'(wlog[0]), 32'h00DEAD);
    checkOutput("second_cpu_run", 32'(cpu_run), 32'd1);

    // Mid-frame restart is ignored; async reset lands between word 3's bytes.
    pulseRestart();
    applyStimulus(8'h00, 0);
    applyStimulus(8'h04, 0);
    idle(0);
    pulseRestart();
    applyStimulus(8'h11, 0);
    applyStimulus(8'h22, 0);
    applyStimulus(8'h33, 0);
    applyStimulus(8'h44, 0);
    applyStimulus(8'h55, 0);
    in_valid = 1'b0;
    checkOutput("pre_reset_words", 32'(words_loaded), 32'd2);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_in_ready", 32'(in_ready), 32'd1);
    checkOutput("async_we", 32'(imem_we), 32'd0);
    checkOutput("async_addr", 32'(imem_addr), 32'(BASE_ADDR));
    checkOutput("async_wdata", 32'(imem_wdata), 32'd0);
    checkOutput("async_words", 32'(words_loaded), 32'd0);
    checkOutput("async_cpu_run", 32'(cpu_run), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    // 02 + CA + FE + BE + EF = 0x377 -> csum 77.
    wlog.delete();
    f = '{8'h00, 8'h02, 8'hCA, 8'hFE, 8'hBE, 8'hEF, 8'h77};
    sendFrame(f, 1);
    checkOutput("post_reset_write0", 32'(wlog[0]), 32'h00CAFE);
    checkOutput("post_reset_write1", 32'(wlog[1]), 32'h01BEEF);
    checkOutput("post_reset_cpu_run", 32'(cpu_run), 32'd1);

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
